// File: rtl/vector_pkg.sv
// Shared vector display list types: ROM entry layout and entry kind encoding.
// Screen ROMs build their contents with make_entry so every list uses the same layout.
package vector_pkg;

   localparam int VEC_ENTRY_W = 18;

   typedef struct packed {
      logic [7:0] x;
      logic [7:0] y;
      logic       line;
      logic       pos;
   } vec_entry_t;

   typedef enum logic [1:0] {
      VK_INVALID = 2'b00,
      VK_MOVE    = 2'b01,
      VK_DRAW    = 2'b10,
      VK_END     = 2'b11
   } vec_kind_e;

   function automatic vec_kind_e entry_kind(input vec_entry_t e);
      return vec_kind_e'({e.line, e.pos});
   endfunction

   function automatic vec_entry_t make_entry(input vec_kind_e kind,
                                             input logic [7:0] x,
                                             input logic [7:0] y);
      vec_entry_t e;
      e.x    = x;
      e.y    = y;
      e.line = kind[1];
      e.pos  = kind[0];
      return e;
   endfunction

endpackage

// File: rtl/vector_hold_timer.sv
// Loadable down-counter with a zero flag; times both the move settle and draw hold.
// Stops at zero so a missed reload can never wrap into a long hold.
module vector_hold_timer #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/vector_list_player.sv
// Plays one vector display list from a combinational point ROM into the X/Y DAC
// registers and beam enable, from base_addr up to the terminator entry.
module vector_list_player
   import vector_pkg::*;
#(
   parameter int ADDRESSWIDTH = 6,
   parameter int DATAWIDTH    = 18,
   parameter int MOVE_CYCLES  = 16,
   parameter int DRAW_CYCLES  = 64,
   parameter int MAX_ENTRIES  = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [ADDRESSWIDTH-1:0] base_addr,
   output logic [ADDRESSWIDTH-1:0] rom_addr,
   input  logic [DATAWIDTH-1:0]    rom_data,
   output logic [7:0]              x_out,
   output logic [7:0]              y_out,
   output logic                    beam_on,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_FETCH     = 3'd1;
   localparam logic [2:0] ST_MOVE_HOLD = 3'd2;
   localparam logic [2:0] ST_DRAW_HOLD = 3'd3;
   localparam logic [2:0] ST_FINISH    = 3'd4;

   localparam int HOLD_MAX = (DRAW_CYCLES > MOVE_CYCLES) ? DRAW_CYCLES : MOVE_CYCLES;
   localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam int CNT_W    = (MAX_ENTRIES > 1) ? $clog2(MAX_ENTRIES) : 1;

   localparam logic [HOLD_W-1:0] MOVE_LOAD  = HOLD_W'(MOVE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] DRAW_LOAD  = HOLD_W'(DRAW_CYCLES - 1);
   localparam logic [CNT_W-1:0]  LAST_ENTRY = CNT_W'(MAX_ENTRIES - 1);

   logic [2:0]        state;
   logic [CNT_W-1:0]  entry_count;
   vec_entry_t        entry;
   vec_kind_e         kind;
   logic              at_limit;
   logic              hold_load;
   logic [HOLD_W-1:0] hold_value;
   logic              hold_dec;
   logic              hold_zero;

   assign entry    = rom_data;
   assign kind     = entry_kind(entry);
   assign at_limit = (entry_count == LAST_ENTRY);

   // The timer is armed only when a MOVE or DRAW is actually accepted at FETCH.
   always_comb begin
      hold_load  = 1'b0;
      hold_value = MOVE_LOAD;
      hold_dec   = 1'b0;
      if (state == ST_FETCH && !at_limit && (kind == VK_MOVE || kind == VK_DRAW)) begin
         hold_load  = 1'b1;
         hold_value = (kind == VK_DRAW) ? DRAW_LOAD : MOVE_LOAD;
      end
      if (state == ST_MOVE_HOLD || state == ST_DRAW_HOLD) begin
         hold_dec = 1'b1;
      end
   end

   vector_hold_timer #(
      .W(HOLD_W)
   ) u_hold_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (hold_load),
      .load_value(hold_value),
      .dec       (hold_dec),
      .zero      (hold_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         rom_addr    <= '0;
         entry_count <= '0;
         x_out       <= '0;
         y_out       <= '0;
         beam_on     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  rom_addr    <= base_addr;
                  entry_count <= '0;
                  busy        <= 1'b1;
                  state       <= ST_FETCH;
               end
            end
            // A terminator wins over the entry limit; anything else at the limit aborts.
            ST_FETCH: begin
               if (kind == VK_END) begin
                  beam_on <= 1'b0;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state   <= ST_FINISH;
               end else if (kind == VK_INVALID || at_limit) begin
                  beam_on <= 1'b0;
                  err     <= 1'b1;
                  busy    <= 1'b0;
                  state   <= ST_FINISH;
               end else begin
                  x_out       <= entry.x;
                  y_out       <= entry.y;
                  beam_on     <= (kind == VK_DRAW);
                  entry_count <= entry_count + CNT_W'(1);
                  state       <= (kind == VK_DRAW) ? ST_DRAW_HOLD : ST_MOVE_HOLD;
               end
            end
            ST_MOVE_HOLD, ST_DRAW_HOLD: begin
               if (hold_zero) begin
                  rom_addr <= rom_addr + ADDRESSWIDTH'(1);
                  state    <= ST_FETCH;
               end
            end
            ST_FINISH: begin
               state <= ST_IDLE;
            end
            default: begin
               beam_on <= 1'b0;
               busy    <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vector_list_player.sv
// Directed self-checking bench for vector_list_player with a behavioural point ROM.
module tb_vector_list_player;
   import vector_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [5:0]  base_addr;
   logic [5:0]  rom_addr;
   logic [17:0] rom_data;
   logic [7:0]  x_out;
   logic [7:0]  y_out;
   logic        beam_on;
   logic        busy;
   logic        done;
   logic        err;

   logic [17:0] rom [64];
   int          checks;
   int          fails;

   assign rom_data = rom[rom_addr];

   vector_list_player #(
      .ADDRESSWIDTH(6),
      .DATAWIDTH   (18),
      .MOVE_CYCLES (16),
      .DRAW_CYCLES (64),
      .MAX_ENTRIES (32)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .base_addr(base_addr),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .x_out    (x_out),
      .y_out    (y_out),
      .beam_on  (beam_on),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Snapshot layout: {rom_addr, x_out, y_out, beam_on, busy, done, err}
   function automatic logic [25:0] snap();
      return {rom_addr, x_out, y_out, beam_on, busy, done, err};
   endfunction

   task automatic do_start(input logic [5:0] a);
      @(negedge clk);
      base_addr = a;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic test_reset();
      logic [25:0] got;
      rst_n = 1'b0;
      start = 1'b0;
      base_addr = 6'd0;
      #3;
      got = snap();
      checks++;
      if (got !== 26'd0) begin
         fails++;
         $display("[TB] FAIL reset_state: got %h expected %h", got, 26'd0);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      got = snap();
      checks++;
      if (got !== 26'd0) begin
         fails++;
         $display("[TB] FAIL idle_after_reset: got %h expected %h", got, 26'd0);
      end
   endtask

   task automatic test_invalid();
      logic [25:0] got;
      do_start(6'd10);
      got = snap();
      checks++;
      if (got !== {6'd10, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         fails++;
         $display("[TB] FAIL invalid_fetch: got %h expected %h", got, {6'd10, 16'd0, 4'b0100});
      end
      @(negedge clk);
      got = snap();
      checks++;
      if (got !== {6'd10, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         fails++;
         $display("[TB] FAIL invalid_err: got %h expected %h", got, {6'd10, 16'd0, 4'b0001});
      end
      @(negedge clk);
      got = snap();
      checks++;
      if (got !== {6'd10, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         fails++;
         $display("[TB] FAIL invalid_idle: got %h expected %h", got, {6'd10, 20'd0});
      end
   endtask

   // Square list at 42..47; clock c is the c-th cycle after the edge accepting start.
   // Optional stray starts (base 0) at clocks inj_a/inj_b must not disturb anything.
   task automatic test_square(input int inj_a, input int inj_b);
      int          seg_start [6] = '{2, 19, 84, 149, 214, 279};
      logic [7:0]  seg_x [5] = '{8'd0, 8'd0, 8'd255, 8'd255, 8'd0};
      logic [7:0]  seg_y [5] = '{8'd255, 8'd0, 8'd0, 8'd255, 8'd255};
      logic        seg_b [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [25:0] exp_v;
      logic [25:0] got;
      logic [25:0] mask;
      int          i;
      int          j;
      do_start(6'd42);
      for (int c = 1; c <= 280; c++) begin
         if (c > 1) @(negedge clk);
         if (c == inj_a || c == inj_b) begin
            base_addr = 6'd0;
            start     = 1'b1;
         end else begin
            start = 1'b0;
         end
         i = 0;
         j = 0;
         for (int k = 0; k < 5; k++) if (seg_start[k] <= c) i = k;
         for (int k = 0; k < 6; k++) if (seg_start[k] - 1 <= c) j = k;
         if (c <= 278) begin
            exp_v = {6'(42 + j), seg_x[i], seg_y[i], seg_b[i], 1'b1, 1'b0, 1'b0};
         end else begin
            exp_v = {6'd47, 8'd0, 8'd255, 1'b0, 1'b0, (c == 279), 1'b0};
         end
         mask = (c == 1) ? {6'h3F, 16'h0000, 4'hF} : '1;
         got  = snap();
         checks++;
         if ((got & mask) !== (exp_v & mask)) begin
            fails++;
            $display("[TB] FAIL square_clk%0d: got %h expected %h", c, got & mask, exp_v & mask);
         end
      end
      start = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [25:0] got;
      base_addr = 6'd42;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      got   = snap();
      checks++;
      if ({got[25:20], got[3:0]} !== {6'd42, 4'b0100}) begin
         fails++;
         $display("[TB] FAIL restart_after_done: got %h expected %h", {got[25:20], got[3:0]}, {6'd42, 4'b0100});
      end
   endtask

   task automatic test_reset_mid_draw();
      logic [25:0] got;
      repeat (49) @(negedge clk);
      got = snap();
      checks++;
      if (got !== {6'd43, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
         fails++;
         $display("[TB] FAIL pre_reset_draw: got %h expected %h", got, {6'd43, 16'd0, 4'b1100});
      end
      #2 rst_n = 1'b0;
      #1;
      got = snap();
      checks++;
      if (got !== 26'd0) begin
         fails++;
         $display("[TB] FAIL async_reset: got %h expected %h", got, 26'd0);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         got = snap();
         checks++;
         if (got !== 26'd0) begin
            fails++;
            $display("[TB] FAIL idle_after_release%0d: got %h expected %h", c, got, 26'd0);
         end
      end
   endtask

   // 40 alternating MOVE/DRAW entries from 60 upward, no terminator; entry e is at (e, 255-e).
   task automatic test_wrap();
      logic [25:0] got;
      logic [7:0]  ex;
      int          len;
      for (int e = 0; e < 40; e++) begin
         ex = 8'(e);
         rom[(60 + e) % 64] = make_entry((e % 2 == 0) ? VK_MOVE : VK_DRAW, ex, 8'd255 - ex);
      end
      do_start(6'd60);
      for (int k = 1; k <= 32; k++) begin
         got = snap();
         checks++;
         if ({got[25:20], got[2:0]} !== {6'((60 + k - 1) % 64), 3'b100}) begin
            fails++;
            $display("[TB] FAIL wrap_fetch%0d: got %h expected %h", k, {got[25:20], got[2:0]}, {6'((60 + k - 1) % 64), 3'b100});
         end
         @(negedge clk);
         got = snap();
         if (k < 32) begin
            ex  = 8'(k - 1);
            len = (k % 2 == 1) ? 17 : 65;
            checks++;
            if (got[19:3] !== {ex, 8'd255 - ex, (k % 2 == 0)}) begin
               fails++;
               $display("[TB] FAIL wrap_entry%0d: got %h expected %h", k, got[19:3], {ex, 8'd255 - ex, (k % 2 == 0)});
            end
            repeat (len - 1) @(negedge clk);
         end else begin
            checks++;
            if (got[19:0] !== {8'd30, 8'd225, 1'b0, 1'b0, 1'b0, 1'b1}) begin
               fails++;
               $display("[TB] FAIL wrap_abort: got %h expected %h", got[19:0], {8'd30, 8'd225, 4'b0001});
            end
         end
      end
      @(negedge clk);
      got = snap();
      checks++;
      if (got[3:0] !== 4'b0000) begin
         fails++;
         $display("[TB] FAIL wrap_idle: got %h expected %h", got[3:0], 4'b0000);
      end
   endtask

   task automatic test_end_only();
      logic [25:0] got;
      rom[5] = make_entry(VK_END, 8'h12, 8'h34);
      do_start(6'd5);
      got = snap();
      checks++;
      if (got !== {6'd5, 8'd30, 8'd225, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         fails++;
         $display("[TB] FAIL end_fetch: got %h expected %h", got, {6'd5, 8'd30, 8'd225, 4'b0100});
      end
      @(negedge clk);
      got = snap();
      checks++;
      if (got !== {6'd5, 8'd30, 8'd225, 1'b0, 1'b0, 1'b1, 1'b0}) begin
         fails++;
         $display("[TB] FAIL end_done: got %h expected %h", got, {6'd5, 8'd30, 8'd225, 4'b0010});
      end
      @(negedge clk);
      got = snap();
      checks++;
      if (got[3:0] !== 4'b0000) begin
         fails++;
         $display("[TB] FAIL end_idle: got %h expected %h", got[3:0], 4'b0000);
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      checks = 0;
      fails  = 0;
      for (int a = 0; a < 64; a++) rom[a] = '0;
      rom[42] = make_entry(VK_MOVE, 8'd0, 8'd255);
      rom[43] = make_entry(VK_DRAW, 8'd0, 8'd0);
      rom[44] = make_entry(VK_DRAW, 8'd255, 8'd0);
      rom[45] = make_entry(VK_DRAW, 8'd255, 8'd255);
      rom[46] = make_entry(VK_DRAW, 8'd0, 8'd255);
      rom[47] = make_entry(VK_END, 8'hAA, 8'h55);
      test_reset();
      test_invalid();
      test_square(0, 0);
      test_square(100, 279);
      test_back_to_back();
      test_reset_mid_draw();
      test_wrap();
      test_end_only();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
